// File: rtl/i4001_rom_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i4001_rom_arbiter
//
// Purpose:
//   Shares the single-ported i4001_rom block RAM between the MCS-4 fetch path
//   and a host loader/debug port. CPU fetches always win. A host access is
//   granted only while the CPU bus is idle and a guard window has expired
//   since the last CPU access. A granted host access takes three cycles
//   (grant, wait, done) and never blocks a CPU read: the memory port is free
//   during the wait and done cycles.
//
// Ports:
//   sysclk        system clock, rising edge
//   poc           asynchronous active-high reset
//   cpu_req       CPU address valid (level)
//   cpu_addr      CPU fetch address
//   cpu_data      registered ROM byte for the CPU
//   host_req      host request (level, held until host_ack)
//   host_we       host write enable, sampled on grant
//   host_addr     host address, sampled on grant
//   host_wdata    host write data, sampled on grant
//   host_ack      one-cycle completion pulse
//   host_rdata    host read data, valid with host_ack and held afterwards
//   host_err      one-cycle pulse with host_ack for a write blocked by wp
//   host_starved  host pending for STARVE_LIMIT cycles without a grant
//   wp            write protect, sampled on grant
//   mem_en        block RAM enable (registered)
//   mem_we        block RAM write enable (registered)
//   mem_addr      block RAM address (registered)
//   mem_wdata     block RAM write data (registered)
//   mem_rdata     block RAM read data, valid one cycle after mem_en
// ---------------------------------------------------------------------------
module i4001_rom_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int GUARD        = 4,
  parameter int STARVE_LIMIT = 255
) (
  input  logic              sysclk,
  input  logic              poc,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_err,
  output logic              host_starved,
  input  logic              wp,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOST_WAIT = 2'd1,
    ST_HOST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        guard_r;
  logic [3:0]        guard_s;
  logic [7:0]        starve_r;
  logic [7:0]        starve_s;
  logic              starved_r;
  logic              starved_s;
  logic              eligible_s;
  logic              grant_s;
  // cpu_rd_r: a CPU read is on the memory port this cycle.
  // cpu_pend_r: mem_rdata carries the CPU byte this cycle.
  logic              cpu_rd_r;
  logic              cpu_pend_r;
  logic [7:0]        cpu_data_r;
  logic [7:0]        cpu_data_s;
  logic              host_wr_r;
  logic              host_wr_s;
  logic              host_wp_r;
  logic              host_wp_s;
  logic              host_ack_r;
  logic              host_ack_s;
  logic              host_err_r;
  logic              host_err_s;
  logic [7:0]        host_rdata_r;
  logic [7:0]        host_rdata_s;
  logic              mem_en_r;
  logic              mem_en_s;
  logic              mem_we_r;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [7:0]        mem_wdata_r;
  logic [7:0]        mem_wdata_s;

  // Host eligibility and grant decision for this cycle.
  always_comb begin
    eligible_s = 1'b0;
    grant_s    = 1'b0;
    if (!cpu_req && (guard_r == 4'd0)) begin
      eligible_s = 1'b1;
    end else begin
      eligible_s = 1'b0;
    end
    if ((state_r == ST_IDLE) && host_req && eligible_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Guard window: reloads on every CPU cycle, counts down while the bus is idle.
  always_comb begin
    guard_s = guard_r;
    if (cpu_req) begin
      guard_s = GUARD_LOAD;
    end else if (guard_r != 4'd0) begin
      guard_s = guard_r - 4'd1;
    end else begin
      guard_s = guard_r;
    end
  end

  // Starvation counter: counts ungranted pending cycles in IDLE, clears with the ack.
  always_comb begin
    starve_s = starve_r;
    if (state_r == ST_HOST_DONE) begin
      starve_s = 8'd0;
    end else if ((state_r == ST_IDLE) && host_req && !grant_s && (starve_r != STARVE_MAX)) begin
      starve_s = starve_r + 8'd1;
    end else begin
      starve_s = starve_r;
    end
    // Flag is derived from the next count so it is registered alongside it.
    starved_s = (starve_s == STARVE_MAX);
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_HOST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOST_WAIT: state_s = ST_HOST_DONE;
      ST_HOST_DONE: state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the memory port and host/CPU result registers.
  always_comb begin
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    host_wr_s    = host_wr_r;
    host_wp_s    = host_wp_r;
    host_ack_s   = 1'b0;
    host_err_s   = 1'b0;
    host_rdata_s = host_rdata_r;
    cpu_data_s   = cpu_data_r;

    // CPU reads take the port unconditionally; a grant is never issued while
    // cpu_req is high, and the host only needs the port in its grant cycle.
    if (cpu_req) begin
      mem_en_s   = 1'b1;
      mem_we_s   = 1'b0;
      mem_addr_s = cpu_addr;
    end else if (grant_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = host_we & ~wp;
      mem_addr_s  = host_addr;
      mem_wdata_s = host_wdata;
    end else begin
      mem_en_s = 1'b0;
      mem_we_s = 1'b0;
    end

    // Remember the access kind and wp as they were at grant time.
    if (grant_s) begin
      host_wr_s = host_we;
      host_wp_s = wp;
    end else begin
      host_wr_s = host_wr_r;
      host_wp_s = host_wp_r;
    end

    case (state_r)
      ST_HOST_DONE: begin
        host_ack_s = 1'b1;
        host_err_s = host_wr_r & host_wp_r;
        if (host_wr_r) begin
          host_rdata_s = host_rdata_r;
        end else begin
          host_rdata_s = mem_rdata;
        end
      end
      default: begin
        host_ack_s   = 1'b0;
        host_err_s   = 1'b0;
        host_rdata_s = host_rdata_r;
      end
    endcase

    if (cpu_pend_r) begin
      cpu_data_s = mem_rdata;
    end else begin
      cpu_data_s = cpu_data_r;
    end
  end

  // Registered outputs, counters and CPU read pipeline.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      guard_r      <= 4'd0;
      starve_r     <= 8'd0;
      starved_r    <= 1'b0;
      cpu_rd_r     <= 1'b0;
      cpu_pend_r   <= 1'b0;
      cpu_data_r   <= 8'd0;
      host_wr_r    <= 1'b0;
      host_wp_r    <= 1'b0;
      host_ack_r   <= 1'b0;
      host_err_r   <= 1'b0;
      host_rdata_r <= 8'd0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'd0;
    end else begin
      guard_r      <= guard_s;
      starve_r     <= starve_s;
      starved_r    <= starved_s;
      cpu_rd_r     <= cpu_req;
      cpu_pend_r   <= cpu_rd_r;
      cpu_data_r   <= cpu_data_s;
      host_wr_r    <= host_wr_s;
      host_wp_r    <= host_wp_s;
      host_ack_r   <= host_ack_s;
      host_err_r   <= host_err_s;
      host_rdata_r <= host_rdata_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
    end
  end

  assign cpu_data     = cpu_data_r;
  assign host_ack     = host_ack_r;
  assign host_rdata   = host_rdata_r;
  assign host_err     = host_err_r;
  assign host_starved = starved_r;
  assign mem_en       = mem_en_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;

endmodule
